mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sits between the EX/MEM pipeline register and the word-addressed data memory; drives the memory's Address/WriteData/MemRead/MemWrite and consumes ReadData.
- Adds byte/halfword loads (sign/zero extension) and byte/halfword stores via read-modify-write.
- Shapes MemWrite into a clean single-cycle pulse (the memory commits on the MemWrite rising edge), stalls the pipeline during multi-cycle stores, and registers results toward WB.

Parameters:
- WORD_ADDR_W, 8, width of the memory word index; Address = zero-extended ExAddress[WORD_ADDR_W+1:2].

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ExValid  in  1  operation present from EX/MEM.
- ExMemRead  in  1  load.
- ExMemWrite  in  1  store (ExMemRead and ExMemWrite both high: treated as a store).
- ExSize  in  2  00 byte, 01 half, 10 word, 11 reserved.
- ExSigned  in  1  sign-extend sub-word loads.
- ExAddress  in  32  byte address.
- ExWriteData  in  32  store data, right-justified.
- Flush  in  1  kill the operation presented in IDLE.
- Address  out  32  to memory (word index).
- WriteData  out  32  to memory.
- MemRead  out  1  to memory.
- MemWrite  out  1  to memory, registered pulse.
- ReadData  in  32  from memory, combinational.
- Stall  out  1  hold EX/MEM and upstream stages.
- WbValid  out  1  registered; result/completion for WB.
- WbLoadData  out  32  registered extended load data.
- WbFault  out  1  registered; misaligned or reserved access.

Behaviour:
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by ExAddress[1:0]; a half uses lanes {a1,a1+1} with a1 = ExAddress[1].
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11. No memory access; WbValid=1 and WbFault=1 next cycle; Stall=0.
- FSM states:
  - IDLE:
    - Load: MemRead=1, Address from Ex; extract/extend ReadData the same cycle; WbValid/WbLoadData next cycle; Stall=0. Back-to-back loads sustain 1/cycle.
    - Word store: drive Address/WriteData from Ex, MemWrite=0, Stall=1; capture both into registers; go to WR_STROBE.
    - Sub-word store: MemRead=1, merge store lanes into ReadData, capture merged word and address; Stall=1; go to WR_SETUP.
  - WR_SETUP: registered Address/WriteData driven, MemWrite=0, Stall=1; go to WR_STROBE.
  - WR_STROBE: MemWrite=1, registered Address/WriteData held, Stall=0; WbValid=1 (WbFault=0) next cycle; return to IDLE.
- Latency: load 1 cycle, word store 2 cycles, sub-word store 3 cycles. Stall pattern is 1,0 for a word store and 1,1,0 for a sub-word store.
- MemWrite is low in every IDLE cycle, so consecutive stores always have at least one low cycle between pulses.
- Address and WriteData are stable from the cycle before MemWrite rises through its high cycle.
- Ex inputs are sampled only in IDLE; upstream holds them while Stall=1.
- Flush in IDLE: no memory access, no WbValid, Stall=0. Flush outside IDLE is ignored; the committed store completes.
- ExValid=0 in IDLE: MemRead=0, MemWrite=0, WbValid=0 next cycle.
- WbLoadData is 0 for stores and faults.
- Reset (async, any state, including mid-RMW): state=IDLE; MemWrite, MemRead, Stall, WbValid, WbFault = 0; WbLoadData, Address, WriteData = 0. An abandoned RMW never produces a MemWrite rising edge.

Decomposition:
- Package mem_ctrl_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - state enum IDLE/WR_SETUP/WR_STROBE.
  - misalignment check function.
- Sub-module mem_lane_align (combinational): load extract/extend and store lane merge, given size, addr[1:0], signed flag.

Test Plan:
- Word 4 preset to 0xABCDEF01:
  - lbu 0x10 -> WbLoadData 0x00000001.
  - lb 0x13 -> 0xFFFFFFAB.
  - lhu 0x12 -> 0x0000ABCD.
  - lh 0x12 -> 0xFFFFABCD.
  - Each with WbValid one cycle later and Stall=0.
- sb 0x11 data 0x00000055 with word 4 = 0xABCDEF01:
  - Stall 1,1,0; exactly one MemWrite pulse in cycle 3 with Address=4, WriteData=0xABCD5501.
  - A following lw 0x10 returns 0xABCD5501.
- sw 0x20 data 0x12345678 then sw 0x24 data 0x9ABCDEF0:
  - MemWrite pattern 0,1,0,1 over 4 cycles.
  - Words 8 and 9 updated accordingly.
- lw 0x06, sh 0x11, size 11:
  - Each gives WbFault=1 with WbValid next cycle.
  - MemRead=0 and MemWrite=0 throughout.
  - Memory unchanged.
- Assert rst_n low during WR_SETUP of sb 0x11:
  - All outputs 0 immediately; MemWrite never rises.
  - Word 4 unchanged; after release, an lw 0x10 behaves normally.
- Flush with sw 0x30 in IDLE:
  - No MemWrite, no WbValid, Stall=0.
  - Word 12 unchanged.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings, FSM state type and alignment check for the memory access controller.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WR_SETUP  = 2'b01,
        WR_STROBE = 2'b10
    } state_e;

    // Reserved size is always treated as a fault.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Little-endian lane logic: load extract/extend and store lane merge into a read word.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    input  logic [31:0] read_data,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = read_data[{addr_lo, 3'b000} +: 8];
        half_sel    = addr_lo[1] ? read_data[31:16] : read_data[15:0];
        load_data   = read_data;
        merged_data = store_data;
        case (size)
            SZ_BYTE: begin
                load_data   = {{24{is_signed & byte_sel[7]}}, byte_sel};
                merged_data = read_data;
                merged_data[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_data   = {{16{is_signed & half_sel[15]}}, half_sel};
                merged_data = read_data;
                if (addr_lo[1]) begin
                    merged_data[31:16] = store_data[15:0];
                end else begin
                    merged_data[15:0] = store_data[15:0];
                end
            end
            default: begin
                load_data   = read_data;
                merged_data = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// EX/MEM to data-memory controller: sub-word loads, read-modify-write sub-word stores,
// single-cycle registered MemWrite pulse and registered writeback results.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ExValid,
    input  logic        ExMemRead,
    input  logic        ExMemWrite,
    input  logic [1:0]  ExSize,
    input  logic        ExSigned,
    input  logic [31:0] ExAddress,
    input  logic [31:0] ExWriteData,
    input  logic        Flush,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] ReadData,
    output logic        Stall,
    output logic        WbValid,
    output logic [31:0] WbLoadData,
    output logic        WbFault
);

    state_e                 state_q, state_d;
    logic [WORD_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   mem_write_q, mem_write_d;
    logic                   wb_valid_q, wb_valid_d;
    logic                   wb_fault_q, wb_fault_d;
    logic [31:0]            wb_load_data_q, wb_load_data_d;

    logic [WORD_ADDR_W-1:0] ex_word;
    logic [WORD_ADDR_W-1:0] addr_out;
    logic [31:0]            wdata_out;
    logic                   access, is_load, is_store, misaligned;
    logic [31:0]            load_data, merged_data;
    logic                   unused_addr_bits;

    assign ex_word          = ExAddress[WORD_ADDR_W+1:2];
    assign unused_addr_bits = ^ExAddress[31:WORD_ADDR_W+2];
    assign is_store         = ExMemWrite;
    assign is_load          = ExMemRead & ~ExMemWrite;
    assign misaligned       = is_misaligned(ExSize, ExAddress[1:0]);
    // rst_n gates the IDLE pass-through so every output reads zero while reset is held.
    assign access           = rst_n & ExValid & ~Flush & (state_q == IDLE) & (is_load | is_store);

    mem_lane_align u_lane_align (
        .size        (ExSize),
        .addr_lo     (ExAddress[1:0]),
        .is_signed   (ExSigned),
        .read_data   (ReadData),
        .store_data  (ExWriteData),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    always_comb begin
        MemRead   = 1'b0;
        Stall     = 1'b0;
        addr_out  = '0;
        wdata_out = '0;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    addr_out = ex_word;
                    if (is_load) begin
                        MemRead = 1'b1;
                    end else if (ExSize == SZ_WORD) begin
                        wdata_out = ExWriteData;
                        Stall     = 1'b1;
                    end else begin
                        MemRead = 1'b1;
                        Stall   = 1'b1;
                    end
                end
            end
            WR_SETUP: begin
                addr_out  = addr_q;
                wdata_out = wdata_q;
                Stall     = 1'b1;
            end
            WR_STROBE: begin
                addr_out  = addr_q;
                wdata_out = wdata_q;
            end
            default: ;
        endcase
    end

    assign Address    = {{(32-WORD_ADDR_W){1'b0}}, addr_out};
    assign WriteData  = wdata_out;
    assign MemWrite   = mem_write_q;
    assign WbValid    = wb_valid_q;
    assign WbFault    = wb_fault_q;
    assign WbLoadData = wb_load_data_q;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        mem_write_d    = 1'b0;
        wb_valid_d     = 1'b0;
        wb_fault_d     = 1'b0;
        wb_load_data_d = '0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_fault_d = 1'b1;
                    end else if (is_load) begin
                        wb_valid_d     = 1'b1;
                        wb_load_data_d = load_data;
                    end else if (ExSize == SZ_WORD) begin
                        addr_d      = ex_word;
                        wdata_d     = ExWriteData;
                        mem_write_d = 1'b1;
                        state_d     = WR_STROBE;
                    end else begin
                        addr_d  = ex_word;
                        wdata_d = merged_data;
                        state_d = WR_SETUP;
                    end
                end
            end
            WR_SETUP: begin
                mem_write_d = 1'b1;
                state_d     = WR_STROBE;
            end
            WR_STROBE: begin
                wb_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            mem_write_q    <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_fault_q     <= 1'b0;
            wb_load_data_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            mem_write_q    <= mem_write_d;
            wb_valid_q     <= wb_valid_d;
            wb_fault_q     <= wb_fault_d;
            wb_load_data_q <= wb_load_data_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a word-addressed memory that commits on MemWrite rising edge.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_signed, flush;
    logic [1:0]  ex_size;
    logic [31:0] ex_address, ex_write_data;
    logic [31:0] mem_address, mem_write_data, read_data, wb_load_data;
    logic        mem_read, mem_write, stall, wb_valid, wb_fault;

    logic [31:0] mem [0:255];
    int          pulses = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        is_store;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic        exp_mem_read;
        logic        exp_fault;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    mem_access_ctrl #(.WORD_ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ExValid     (ex_valid),
        .ExMemRead   (ex_mem_read),
        .ExMemWrite  (ex_mem_write),
        .ExSize      (ex_size),
        .ExSigned    (ex_signed),
        .ExAddress   (ex_address),
        .ExWriteData (ex_write_data),
        .Flush       (flush),
        .Address     (mem_address),
        .WriteData   (mem_write_data),
        .MemRead     (mem_read),
        .MemWrite    (mem_write),
        .ReadData    (read_data),
        .Stall       (stall),
        .WbValid     (wb_valid),
        .WbLoadData  (wb_load_data),
        .WbFault     (wb_fault)
    );

    always #5 clk = ~clk;

    assign read_data = mem[mem_address[7:0]];

    always @(posedge mem_write) begin
        mem[mem_address[7:0]] <= mem_write_data;
        pulses = pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic rd, input logic wr,
                                 input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic fl);
        ex_valid      = valid;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_size       = size;
        ex_signed     = sgn;
        ex_address    = addr;
        ex_write_data = wdata;
        flush         = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addr"}, mem_address, 32'h0);
        checkOutput({tag, "_wdata"}, mem_write_data, 32'h0);
        checkOutput({tag, "_memread"}, 32'(mem_read), 32'h0);
        checkOutput({tag, "_memwrite"}, 32'(mem_write), 32'h0);
        checkOutput({tag, "_stall"}, 32'(stall), 32'h0);
        checkOutput({tag, "_wbvalid"}, 32'(wb_valid), 32'h0);
        checkOutput({tag, "_wbfault"}, 32'(wb_fault), 32'h0);
        checkOutput({tag, "_wbdata"}, wb_load_data, 32'h0);
    endtask

    initial begin
        int base_pulses;

        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | 32'(i);
        mem[4]  = 32'hABCDEF01;
        mem[12] = 32'hC0C0C0C0;

        vecs[0] = '{1'b0, SZ_BYTE, 1'b0, 32'h10, 1'b1, 1'b0, 32'h00000001};
        vecs[1] = '{1'b0, SZ_BYTE, 1'b1, 32'h13, 1'b1, 1'b0, 32'hFFFFFFAB};
        vecs[2] = '{1'b0, SZ_HALF, 1'b0, 32'h12, 1'b1, 1'b0, 32'h0000ABCD};
        vecs[3] = '{1'b0, SZ_HALF, 1'b1, 32'h12, 1'b1, 1'b0, 32'hFFFFABCD};
        vecs[4] = '{1'b0, SZ_WORD, 1'b0, 32'h10, 1'b1, 1'b0, 32'hABCDEF01};
        vecs[5] = '{1'b0, SZ_BYTE, 1'b1, 32'h11, 1'b1, 1'b0, 32'hFFFFFFEF};
        vecs[6] = '{1'b0, SZ_HALF, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0000EF01};
        vecs[7] = '{1'b0, SZ_WORD, 1'b0, 32'h06, 1'b0, 1'b1, 32'h00000000};
        vecs[8] = '{1'b1, SZ_HALF, 1'b0, 32'h11, 1'b0, 1'b1, 32'h00000000};
        vecs[9] = '{1'b0, SZ_RSVD, 1'b0, 32'h10, 1'b0, 1'b1, 32'h00000000};

        applyStimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        checkAllZero("reset");
        #20;
        tick();
        rst_n = 1'b1;
        tick();
        checkAllZero("idle");

        // Back-to-back loads and faulting accesses, one per cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, !vecs[i].is_store, vecs[i].is_store, vecs[i].size, vecs[i].sgn,
                          vecs[i].addr, 32'h0, 1'b0);
            #1;
            checkOutput($sformatf("v%0d_stall", i), 32'(stall), 32'h0);
            checkOutput($sformatf("v%0d_memread", i), 32'(mem_read), 32'(vecs[i].exp_mem_read));
            checkOutput($sformatf("v%0d_memwrite", i), 32'(mem_write), 32'h0);
            tick();
            checkOutput($sformatf("v%0d_wbvalid", i), 32'(wb_valid), 32'h1);
            checkOutput($sformatf("v%0d_wbfault", i), 32'(wb_fault), 32'(vecs[i].exp_fault));
            checkOutput($sformatf("v%0d_wbdata", i), wb_load_data, vecs[i].exp_data);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("nop_wbvalid", 32'(wb_valid), 32'h0);
        checkOutput("fault_pulses", 32'(pulses), 32'h0);
        checkOutput("fault_mem4", mem[4], 32'hABCDEF01);

        // sb 0x11: stall 1,1,0 and a single strobe in the third cycle.
        applyStimulus(1'b1, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h00000055, 1'b0);
        #1;
        checkOutput("sb_c1_stall", 32'(stall), 32'h1);
        checkOutput("sb_c1_memread", 32'(mem_read), 32'h1);
        checkOutput("sb_c1_memwrite", 32'(mem_write), 32'h0);
        checkOutput("sb_c1_addr", mem_address, 32'h4);
        tick();
        checkOutput("sb_c2_stall", 32'(stall), 32'h1);
        checkOutput("sb_c2_memwrite", 32'(mem_write), 32'h0);
        checkOutput("sb_c2_addr", mem_address, 32'h4);
        checkOutput("sb_c2_wdata", mem_write_data, 32'hABCD5501);
        tick();
        checkOutput("sb_c3_stall", 32'(stall), 32'h0);
        checkOutput("sb_c3_memwrite", 32'(mem_write), 32'h1);
        checkOutput("sb_c3_addr", mem_address, 32'h4);
        checkOutput("sb_c3_wdata", mem_write_data, 32'hABCD5501);
        applyStimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("sb_wbvalid", 32'(wb_valid), 32'h1);
        checkOutput("sb_wbfault", 32'(wb_fault), 32'h0);
        checkOutput("sb_wbdata", wb_load_data, 32'h0);
        checkOutput("sb_memwrite_low", 32'(mem_write), 32'h0);
        checkOutput("sb_pulses", 32'(pulses), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0);
        tick();
        checkOutput("sb_lw_data", wb_load_data, 32'hABCD5501);

        // Two word stores: MemWrite 0,1,0,1.
        base_pulses = pulses;
        applyStimulus(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h12345678, 1'b0);
        #1;
        checkOutput("sw1_c1_memwrite", 32'(mem_write), 32'h0);
        checkOutput("sw1_c1_stall", 32'(stall), 32'h1);
        checkOutput("sw1_c1_addr", mem_address, 32'h8);
        checkOutput("sw1_c1_wdata", mem_write_data, 32'h12345678);
        tick();
        checkOutput("sw1_c2_memwrite", 32'(mem_write), 32'h1);
        checkOutput("sw1_c2_stall", 32'(stall), 32'h0);
        checkOutput("sw1_c2_addr", mem_address, 32'h8);
        applyStimulus(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h24, 32'h9ABCDEF0, 1'b0);
        tick();
        checkOutput("sw2_c3_memwrite", 32'(mem_write), 32'h0);
        checkOutput("sw2_c3_stall", 32'(stall), 32'h1);
        checkOutput("sw1_wbvalid", 32'(wb_valid), 32'h1);
        tick();
        checkOutput("sw2_c4_memwrite", 32'(mem_write), 32'h1);
        checkOutput("sw2_c4_addr", mem_address, 32'h9);
        applyStimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("sw2_wbvalid", 32'(wb_valid), 32'h1);
        checkOutput("sw_mem8", mem[8], 32'h12345678);
        checkOutput("sw_mem9", mem[9], 32'h9ABCDEF0);
        checkOutput("sw_pulses", 32'(pulses - base_pulses), 32'h2);

        // Reset in WR_SETUP abandons the read-modify-write.
        base_pulses = pulses;
        applyStimulus(1'b1, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h00000077, 1'b0);
        tick();
        checkOutput("rmw_setup_stall", 32'(stall), 32'h1);
        checkOutput("rmw_setup_wdata", mem_write_data, 32'hABCD7701);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_mid");
        tick();
        tick();
        checkAllZero("rst_hold");
        applyStimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("rst_pulses", 32'(pulses - base_pulses), 32'h0);
        checkOutput("rst_mem4", mem[4], 32'hABCD5501);
        applyStimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0);
        #1;
        checkOutput("rst_lw_memread", 32'(mem_read), 32'h1);
        tick();
        checkOutput("rst_lw_wbvalid", 32'(wb_valid), 32'h1);
        checkOutput("rst_lw_data", wb_load_data, 32'hABCD5501);

        // Flushed word store in IDLE does nothing.
        base_pulses = pulses;
        applyStimulus(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h11112222, 1'b1);
        #1;
        checkOutput("flush_stall", 32'(stall), 32'h0);
        checkOutput("flush_memread", 32'(mem_read), 32'h0);
        tick();
        checkOutput("flush_wbvalid", 32'(wb_valid), 32'h0);
        checkOutput("flush_memwrite", 32'(mem_write), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("flush_memwrite2", 32'(mem_write), 32'h0);
        checkOutput("flush_pulses", 32'(pulses - base_pulses), 32'h0);
        checkOutput("flush_mem12", mem[12], 32'hC0C0C0C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
